pulse_gen: RTL and testbench

- Counterpart to the positive-edge detector: it produces the level waveform that the detector consumes.
- Converts single-cycle trigger requests into clean high pulses of programmable width, each followed by a programmable low gap, so every request yields exactly one detectable rising edge.
- Requests that arrive while a pulse or gap is in progress are queued in a pending counter. Requests beyond the queue capacity are dropped and flagged.
- Sits in front of pedge, and is used as the stimulus source for its bench.

---
 rtl/pulse_gen_pkg.sv | 10 +
 rtl/pg_down_counter.sv | 28 ++
 rtl/pulse_gen.sv | 126 ++++++++++++
 tb/tb_pulse_gen.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the pulse generator.
package pulse_gen_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, GAP} pg_state_t;

  function automatic logic [31:0] clamp1(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/pg_down_counter.sv
// Loadable down counter that holds at zero; tc is high while the count is zero.
// Load has priority over enable; 1-cycle load latency, no backpressure.
module pg_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/pulse_gen.sv
// Turns trigger requests into high pulses of width w followed by a low gap g, queueing extras.
// o_sig rises 1 cycle after an idle trigger; requests beyond MAX_PEND are dropped with o_ovf.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int  CW       = 8,
  parameter int  MAX_PEND = 7,
  localparam int PW       = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_trig,
  input  logic [CW-1:0] i_width,
  input  logic [CW-1:0] i_gap,
  output logic          o_sig,
  output logic          o_busy,
  output logic [PW-1:0] o_pend,
  output logic          o_ovf
);

  pg_state_t     state;
  logic [CW-1:0] w_now, g_now, g_lat;
  logic          cnt_load, cnt_en, cnt_tc;
  logic [CW-1:0] cnt_val;
  logic          gap_end, launch;

  assign w_now = CW'(clamp1(32'(i_width)));
  assign g_now = CW'(clamp1(32'(i_gap)));

  // A trigger on the gap's last edge counts toward the relaunch decision.
  assign gap_end = (state == GAP) && cnt_tc;
  assign launch  = gap_end && (i_trig || (o_pend != '0));

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      IDLE: begin
        if (i_trig) begin
          cnt_load = 1'b1;
          cnt_val  = w_now - CW'(1);
        end
      end
      HIGH: begin
        if (cnt_tc) begin
          cnt_load = 1'b1;
          cnt_val  = g_lat - CW'(1);
        end
      end
      GAP: begin
        if (launch) begin
          cnt_load = 1'b1;
          cnt_val  = w_now - CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign cnt_en = (state != IDLE);

  pg_down_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      o_sig  <= 1'b0;
      o_busy <= 1'b0;
      o_pend <= '0;
      o_ovf  <= 1'b0;
      g_lat  <= '0;
    end else begin
      o_ovf <= 1'b0;
      case (state)
        IDLE: begin
          if (i_trig) begin
            state  <= HIGH;
            o_sig  <= 1'b1;
            o_busy <= 1'b1;
            g_lat  <= g_now;
          end
        end
        HIGH: begin
          if (i_trig) begin
            if (o_pend < PW'(MAX_PEND)) o_pend <= o_pend + PW'(1);
            else                        o_ovf  <= 1'b1;
          end
          if (cnt_tc) begin
            state <= GAP;
            o_sig <= 1'b0;
          end
        end
        GAP: begin
          if (gap_end) begin
            if (launch) begin
              // Trigger plus dequeue nets to zero change in the queue.
              state <= HIGH;
              o_sig <= 1'b1;
              g_lat <= g_now;
              if (!i_trig) o_pend <= o_pend - PW'(1);
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end else if (i_trig) begin
            if (o_pend < PW'(MAX_PEND)) o_pend <= o_pend + PW'(1);
            else                        o_ovf  <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          o_sig  <= 1'b0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Randomized and directed bench for pulse_gen against a period-based reference model.
module tb_pulse_gen;

  localparam int CW       = 8;
  localparam int MAX_PEND = 7;
  localparam int PW       = $clog2(MAX_PEND + 1);

  logic          clk;
  logic          reset;
  logic          i_trig;
  logic [CW-1:0] i_width;
  logic [CW-1:0] i_gap;
  logic          o_sig;
  logic          o_busy;
  logic [PW-1:0] o_pend;
  logic          o_ovf;

  int total = 0;
  int bad   = 0;

  // Model: a pulse is a period of w+g cycles; pos counts cycles since launch.
  int m_busy = 0, m_pos = 0, m_w = 1, m_g = 1, m_pend = 0, m_ovf = 0;
  int rises = 0, ovfs = 0, trigs = 0;
  logic prev_sig = 1'b0;

  pulse_gen #(.CW(CW), .MAX_PEND(MAX_PEND)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_trig  (i_trig),
    .i_width (i_width),
    .i_gap   (i_gap),
    .o_sig   (o_sig),
    .o_busy  (o_busy),
    .o_pend  (o_pend),
    .o_ovf   (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampv(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_pos = 0; m_w = 1; m_g = 1; m_pend = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    int eff;
    m_ovf = 0;
    if (m_busy == 0) begin
      if (i_trig) begin
        m_busy = 1; m_pos = 0;
        m_w = clampv(int'(i_width)); m_g = clampv(int'(i_gap));
      end
    end else if (m_pos + 1 == m_w + m_g) begin
      eff = m_pend + int'(i_trig);
      if (eff > 0) begin
        m_pend = eff - 1; m_pos = 0;
        m_w = clampv(int'(i_width)); m_g = clampv(int'(i_gap));
      end else begin
        m_busy = 0;
      end
    end else begin
      m_pos++;
      if (i_trig) begin
        if (m_pend < MAX_PEND) m_pend++;
        else m_ovf = 1;
      end
    end
  endtask

  task automatic check_all();
    check("sig",  int'(o_sig),  (m_busy != 0 && m_pos < m_w) ? 1 : 0);
    check("busy", int'(o_busy), m_busy);
    check("pend", int'(o_pend), m_pend);
    check("ovf",  int'(o_ovf),  m_ovf);
  endtask

  task automatic tick(input logic trig, input int w, input int g);
    logic [31:0] wv, gv;
    wv = w; gv = g;
    i_trig  = trig;
    i_width = wv[CW-1:0];
    i_gap   = gv[CW-1:0];
    if (trig) trigs++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (o_sig && !prev_sig) rises++;
    prev_sig = o_sig;
    if (o_ovf) ovfs++;
    check_all();
  endtask

  initial begin
    int r0, o0, t0, pct, w, g;
    reset = 1'b1; i_trig = 1'b0; i_width = '0; i_gap = '0;
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;

    // Single request, then idle drain.
    r0 = rises;
    tick(1'b1, 3, 2);
    repeat (8) tick(1'b0, 3, 2);
    check("single_pulses", rises - r0, 1);

    // Zero clamp with back-to-back triggers.
    r0 = rises;
    tick(1'b1, 0, 0);
    tick(1'b1, 0, 0);
    repeat (6) tick(1'b0, 0, 0);
    check("clamp_pulses", rises - r0, 2);

    // Burst into saturation; every accepted request must produce a pulse.
    r0 = rises; o0 = ovfs; t0 = trigs;
    repeat (10) tick(1'b1, 4, 4);
    repeat (90) tick(1'b0, 4, 4);
    check("burst_conserve", rises - r0, (trigs - t0) - (ovfs - o0));

    // Trigger on the gap's final edge with an empty queue.
    tick(1'b1, 2, 2);
    repeat (3) tick(1'b0, 2, 2);
    tick(1'b1, 2, 2);
    repeat (8) tick(1'b0, 2, 2);

    // Width change while high affects only the queued pulse.
    tick(1'b1, 5, 2);
    tick(1'b1, 2, 2);
    repeat (15) tick(1'b0, 2, 2);

    // Maximum width.
    tick(1'b1, 255, 1);
    repeat (260) tick(1'b0, 255, 1);

    // Async reset mid-pulse with three queued requests.
    tick(1'b1, 6, 3);
    repeat (3) tick(1'b1, 6, 3);
    i_trig = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset = 1'b0;
    prev_sig = o_sig;
    repeat (10) tick(1'b0, 6, 3);

    // Randomized traffic with varying trigger density.
    r0 = rises; o0 = ovfs; t0 = trigs;
    pct = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) pct = $urandom_range(5, 90);
      w = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      g = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      tick(($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0, w, g);
    end
    repeat (120) tick(1'b0, 1, 1);
    check("rand_conserve", rises - r0, (trigs - t0) - (ovfs - o0));
    check("rand_idle_busy", int'(o_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
